// File: rtl/pam_4_channel_pkg.sv
// rtl/pam_4_channel_pkg.sv - shared constants and helpers for the PAM-4 channel model
// Holds mid level, tap fixed-point format, default taps and the noise LFSR definition.
package pam_4_channel_pkg;

   localparam int DEF_SIGNAL_RESOLUTION = 8;
   localparam int DEF_TAP_WIDTH         = 8;

   localparam int MID_LEVEL = 1 << (DEF_SIGNAL_RESOLUTION - 1);
   localparam int TAP_FRAC  = DEF_TAP_WIDTH - 2;
   localparam int TAP_ONE   = 1 << TAP_FRAC;

   localparam int DEFAULT_CURSOR_TAP = TAP_ONE;
   localparam int DEFAULT_POST_TAP   = 0;

   // x^16 + x^14 + x^13 + x^11 + 1, bit i set for term x^(i+1)
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_POLY = 16'hB400;

   function automatic int mid_level(input int res);
      return 1 << (res - 1);
   endfunction

   function automatic int tap_frac(input int tw);
      return tw - 2;
   endfunction

   // Scaled so the cursor tap is unity gain in any tap width.
   function automatic int default_tap(input int idx, input int tw);
      if (idx == 0)
         return DEFAULT_CURSOR_TAP << (tap_frac(tw) - TAP_FRAC);
      return DEFAULT_POST_TAP;
   endfunction

   // A right-shifting Fibonacci register taps state bit (16-t) for term x^t.
   function automatic logic [15:0] lfsr_fb_mask(input logic [15:0] poly);
      logic [15:0] m;
      m = '0;
      for (int i = 0; i < 16; i++)
         m[15 - i] = poly[i];
      return m;
   endfunction

endpackage

// File: rtl/pam_4_channel_noise_lfsr.sv
// rtl/pam_4_channel_noise_lfsr.sv - 16-bit Fibonacci LFSR used as channel noise source
// Advances once per enabled cycle; resets to the package seed.
module channel_noise_lfsr
   import pam_4_channel_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        en_i,
   output logic [15:0] state_o
);

   localparam logic [15:0] FB_MASK = lfsr_fb_mask(LFSR_POLY);

   logic [15:0] state_q;
   logic [15:0] state_d;

   always_comb begin
      state_d = state_q;
      if (en_i)
         state_d = {^(state_q & FB_MASK), state_q[15:1]};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state_q <= LFSR_SEED;
      else
         state_q <= state_d;
   end

   assign state_o = state_q;

endmodule

// File: rtl/pam_4_channel.sv
// rtl/pam_4_channel.sv - PAM-4 channel ISI FIR with rounding and saturation, 2-cycle latency
// Optional additive noise when PAM_4_CHANNEL_NOISE_EN is defined.
module pam_4_channel
   import pam_4_channel_pkg::*;
#(
   parameter int SIGNAL_RESOLUTION = 8,
   parameter int NUM_TAPS          = 4,
   parameter int TAP_WIDTH         = 8
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [SIGNAL_RESOLUTION-1:0]  voltage_level_in,
   input  logic                          voltage_level_in_valid,
   input  logic                          tap_wr_en,
   input  logic [$clog2(NUM_TAPS)-1:0]   tap_wr_addr,
   input  logic [TAP_WIDTH-1:0]          tap_wr_data,
   output logic [SIGNAL_RESOLUTION-1:0]  voltage_level_out,
   output logic                          voltage_level_out_valid
);

   localparam int SR    = SIGNAL_RESOLUTION;
   localparam int AW    = $clog2(NUM_TAPS);
   localparam int PW    = SR + TAP_WIDTH;
   localparam int ACC_W = SR + TAP_WIDTH + AW;
   localparam int FRAC  = tap_frac(TAP_WIDTH);

   localparam logic signed [ACC_W-1:0] RND_C = ACC_W'(1 << (FRAC - 1));
   localparam logic signed [ACC_W-1:0] MID_C = ACC_W'(mid_level(SR));
   localparam logic signed [ACC_W-1:0] MAX_C = ACC_W'((1 << SR) - 1);
   localparam logic [SR-1:0]           MID_OUT = SR'(mid_level(SR));

   logic signed [TAP_WIDTH-1:0] tap_q  [NUM_TAPS];
   logic signed [SR-1:0]        hist_q [NUM_TAPS-1];
   logic signed [SR-1:0]        win    [NUM_TAPS];
   logic signed [PW-1:0]        prod_d [NUM_TAPS];
   logic signed [PW-1:0]        prod_q [NUM_TAPS];
   logic                        valid1_q;
   logic                        valid2_q;
   logic [SR-1:0]               out_q;
   logic signed [SR-1:0]        x_in;
   logic signed [ACC_W-1:0]     acc_d;
   logic signed [ACC_W-1:0]     lvl_d;
   logic [SR-1:0]               sat_d;

   // Offset-binary to two's complement is an MSB flip.
   assign x_in = {~voltage_level_in[SR-1], voltage_level_in[SR-2:0]};

`ifdef PAM_4_CHANNEL_NOISE_EN
   logic [15:0]        lfsr_state;
   logic signed [3:0]  noise1_q;

   channel_noise_lfsr u_noise (
      .clk     (clk),
      .rstn    (rstn),
      .en_i    (voltage_level_in_valid),
      .state_o (lfsr_state)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         noise1_q <= '0;
      else if (voltage_level_in_valid)
         noise1_q <= lfsr_state[3:0];
   end
`endif

   // Window seen by the taps: the incoming sample plus the stored history.
   always_comb begin
      win[0] = x_in;
      for (int k = 1; k < NUM_TAPS; k++)
         win[k] = hist_q[k-1];
      for (int k = 0; k < NUM_TAPS; k++)
         prod_d[k] = PW'(tap_q[k]) * PW'(win[k]);
   end

   always_comb begin
      acc_d = '0;
      for (int k = 0; k < NUM_TAPS; k++)
         acc_d = acc_d + ACC_W'(prod_q[k]);
      lvl_d = ((acc_d + RND_C) >>> FRAC) + MID_C;
`ifdef PAM_4_CHANNEL_NOISE_EN
      lvl_d = lvl_d + ACC_W'(noise1_q);
`endif
      if (lvl_d[ACC_W-1])
         sat_d = '0;
      else if (lvl_d > MAX_C)
         sat_d = '1;
      else
         sat_d = lvl_d[SR-1:0];
   end

   // Taps written at an edge are seen only by samples accepted on later edges.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            tap_q[k]  <= TAP_WIDTH'(default_tap(k, TAP_WIDTH));
            prod_q[k] <= '0;
         end
         for (int k = 0; k < NUM_TAPS - 1; k++)
            hist_q[k] <= '0;
         valid1_q <= 1'b0;
         valid2_q <= 1'b0;
         out_q    <= MID_OUT;
      end else begin
         for (int k = 0; k < NUM_TAPS; k++)
            if (tap_wr_en && (tap_wr_addr == AW'(k)))
               tap_q[k] <= tap_wr_data;
         valid1_q <= voltage_level_in_valid;
         if (voltage_level_in_valid) begin
            for (int k = 0; k < NUM_TAPS; k++)
               prod_q[k] <= prod_d[k];
            for (int k = NUM_TAPS - 2; k > 0; k--)
               hist_q[k] <= hist_q[k-1];
            hist_q[0] <= x_in;
         end
         valid2_q <= valid1_q;
         if (valid1_q)
            out_q <= sat_d;
      end
   end

   assign voltage_level_out       = out_q;
   assign voltage_level_out_valid = valid2_q;

endmodule
